// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
//   Shared definitions for the reset-enable sequencer slice.
//   state_t   : sequencer FSM state (IDLE, ASSERT, RELEASE, ACK), 2-bit encoded.
//   cnt_width : width of the hold/settle down-counter for given cycle counts.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  // Counter must hold max(hold, settle); never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned settle);
    int unsigned m;
    m = (hold > settle) ? hold : settle;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_rr_arbiter.sv
// rst_rr_arbiter
//   Combinational round-robin arbiter: grants the first requesting index at or
//   after i_ptr, wrapping around N_CH.
//   i_req   : request vector
//   i_ptr   : round-robin start index
//   o_valid : at least one request present
//   o_grant : one-hot grant (zero when no request)
//   o_idx   : index of the granted channel
module rst_rr_arbiter #(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [N_CH-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx
);

  int unsigned      w_k;
  logic [IDX_W-1:0] w_k_idx;

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_k     = 0;
    w_k_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_k = 32'(i_ptr) + i;
      if (w_k >= N_CH) w_k = w_k - N_CH;
      w_k_idx = IDX_W'(w_k);
      if (!o_valid && i_req[w_k_idx]) begin
        o_valid          = 1'b1;
        o_grant[w_k_idx] = 1'b1;
        o_idx            = w_k_idx;
      end
    end
  end

endmodule

// File: rtl/rst_enable_sequencer.sv
// rst_enable_sequencer
//   Serves soft-reset requests one channel at a time: asserts a one-hot
//   reset-enable strobe for HOLD_CYC cycles, waits SETTLE_CYC cycles, then
//   pulses a one-cycle per-channel acknowledge.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   lock_i     : blocks new grants; an active sequence still completes
//   req_i      : level request per channel
//   rst_en_o   : registered one-hot reset-enable strobe
//   ack_o      : registered one-cycle completion pulse
//   busy_o     : FSM not idle
//   cur_ch_o   : channel being served, held from grant through ACK
module rst_enable_sequencer
  import rst_seq_pkg::*;
#(
  parameter  int unsigned N_CH       = 4,
  parameter  int unsigned HOLD_CYC   = 4,
  parameter  int unsigned SETTLE_CYC = 2,
  localparam int unsigned CNT_W      = cnt_width(HOLD_CYC, SETTLE_CYC),
  localparam int unsigned IDX_W      = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_i,
  input  logic [N_CH-1:0]  req_i,
  output logic [N_CH-1:0]  rst_en_o,
  output logic [N_CH-1:0]  ack_o,
  output logic             busy_o,
  output logic [IDX_W-1:0] cur_ch_o
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_cur;
  logic [N_CH-1:0]  r_rst_en;
  logic [N_CH-1:0]  r_ack;

  logic             w_valid;
  logic [N_CH-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic [N_CH-1:0]  w_cur_oh;

  rst_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_cur_oh = {{(N_CH-1){1'b0}}, 1'b1} << r_cur;

  // Strobe is loaded from the arbiter grant on the grant edge so the first
  // strobe cycle is the cycle right after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_cur    <= '0;
      r_rst_en <= '0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid && !lock_i) begin
            r_cur    <= w_idx;
            r_ptr    <= (w_idx == IDX_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
            r_cnt    <= HOLD_LD;
            r_rst_en <= w_grant;
            r_state  <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (r_cnt == '0) begin
            r_rst_en <= '0;
            r_cnt    <= SETTLE_LD;
            if (SETTLE_CYC == 0) begin
              r_ack   <= w_cur_oh;
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == '0) begin
            r_ack   <= w_cur_oh;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rst_en_o = r_rst_en;
  assign ack_o    = r_ack;
  assign busy_o   = (r_state != ST_IDLE);
  assign cur_ch_o = r_cur;

endmodule

// File: tb/tb_rst_enable_sequencer.sv
// tb_rst_enable_sequencer
//   Two instances: u_dut0 (HOLD=4, SETTLE=2) and u_dut1 (HOLD=1, SETTLE=0).
//   A timeline reference model (cycles elapsed since grant) predicts every
//   output at each falling edge; directed scenarios plus random traffic.
module tb_rst_enable_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned H0 = 4;
  localparam int unsigned S0 = 2;
  localparam int unsigned H1 = 1;
  localparam int unsigned S1 = 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0][3:0] req;
  logic [1:0]      lock;
  logic [1:0][3:0] rst_en;
  logic [1:0][3:0] ack;
  logic [1:0]      busy;
  logic [1:0][1:0] cur;

  always #5 clk = ~clk;

  rst_enable_sequencer #(.N_CH(4), .HOLD_CYC(H0), .SETTLE_CYC(S0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .lock_i(lock[0]), .req_i(req[0]),
    .rst_en_o(rst_en[0]), .ack_o(ack[0]), .busy_o(busy[0]), .cur_ch_o(cur[0])
  );

  rst_enable_sequencer #(.N_CH(4), .HOLD_CYC(H1), .SETTLE_CYC(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .lock_i(lock[1]), .req_i(req[1]),
    .rst_en_o(rst_en[1]), .ack_o(ack[1]), .busy_o(busy[1]), .cur_ch_o(cur[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned hold_of(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int unsigned total_of(input int i);
    return (i == 0) ? (1 + H0 + S0) : (1 + H1 + S1);
  endfunction

  // Reference model: m_el counts cycles since the grant edge (1 = first strobe).
  bit          m_act[2];
  int unsigned m_el[2];
  int unsigned m_ch[2];
  int unsigned m_ptr[2];

  initial begin
    logic [3:0] e_en, e_ack;
    int unsigned c;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_act[i] = 1'b0; m_el[i] = 0; m_ch[i] = 0; m_ptr[i] = 0;
        end
        e_en  = (m_act[i] && m_el[i] <= hold_of(i)) ? (4'(1) << m_ch[i]) : 4'd0;
        e_ack = (m_act[i] && m_el[i] == total_of(i)) ? (4'(1) << m_ch[i]) : 4'd0;
        check($sformatf("rst_en%0d", i), 32'(rst_en[i]), 32'(e_en));
        check($sformatf("ack%0d", i), 32'(ack[i]), 32'(e_ack));
        check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_act[i]));
        check($sformatf("onehot0_%0d", i), 32'($onehot0(rst_en[i])), 32'd1);
        if (m_act[i]) check($sformatf("cur%0d", i), 32'(cur[i]), m_ch[i]);
        // advance to the state after the coming rising edge
        if (rst_n) begin
          if (m_act[i]) begin
            if (m_el[i] == total_of(i)) m_act[i] = 1'b0;
            else m_el[i]++;
          end else if (req[i] != 4'd0 && !lock[i]) begin
            for (int k = 0; k < N; k++) begin
              c = (m_ptr[i] + k) % N;
              if (req[i][c]) begin
                m_ch[i] = c;
                break;
              end
            end
            m_ptr[i] = (m_ch[i] + 1) % N;
            m_act[i] = 1'b1;
            m_el[i]  = 1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise req for one channel, count strobe cycles, optionally drop req on the
  // drop_on-th strobe cycle, drop on ack; check hold length and latency.
  task automatic run_seq(input int i, input int ch, input int drop_on, input string tag);
    int n_en, first, idx;
    bit seen;
    n_en = 0; first = -1; seen = 1'b0;
    req[i][ch] = 1'b1;
    for (idx = 0; idx < 40 && !seen; idx++) begin
      tick(1);
      if (rst_en[i][ch]) begin
        n_en++;
        if (first < 0) first = idx;
        if (n_en == drop_on) req[i][ch] = 1'b0;
      end
      if (ack[i][ch]) begin
        seen = 1'b1;
        req[i][ch] = 1'b0;
        check({tag, "_latency"}, 32'(idx - first), hold_of(i) + total_of(i) - 1 - hold_of(i));
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    check({tag, "_strobe_cycles"}, 32'(n_en), hold_of(i));
    req[i][ch] = 1'b0;
  endtask

  initial begin
    bit   seen;
    int   last_t, t;
    logic [3:0] a;
    req  = '0;
    lock = '0;
    rst_n = 1'b0;
    tick(3);
    check("reset_rst_en", 32'(rst_en), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cur", 32'(cur), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: single request on channel 2
    run_seq(0, 2, 0, "t1");
    tick(1);
    check("t1_idle_after", 32'(busy[0]), 32'd0);

    // 2: all four requesting from ptr=0, each dropped on its ack
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
    req[0] = 4'b1111;
    last_t = -1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        tick(1);
        if (ack[0] != 4'd0) begin
          seen = 1'b1;
          a = ack[0];
          req[0] = req[0] & ~a;
          check("t2_order", 32'(a), 32'(4'(1) << k));
          t = int'($time / 10);
          if (last_t >= 0) check("t2_ack_spacing", 32'(t - last_t), 2 + H0 + S0);
          last_t = t;
        end
      end
      check("t2_ack_seen", 32'(seen), 32'd1);
    end

    // 3: lock blocks grants, does not abort an active sequence
    tick(2);
    lock[0] = 1'b1;
    req[0]  = 4'b0010;
    tick(5);
    check("t3_locked_busy", 32'(busy[0]), 32'd0);
    check("t3_locked_en", 32'(rst_en[0]), 32'd0);
    lock[0] = 1'b0;
    tick(1);
    check("t3_grant_next", 32'(rst_en[0]), 32'b0010);
    tick(1);
    lock[0] = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      tick(1);
      if (ack[0][1]) seen = 1'b1;
    end
    check("t3_ack_under_lock", 32'(seen), 32'd1);
    tick(3);
    check("t3_no_regrant", 32'(busy[0]), 32'd0);
    req[0] = '0; lock[0] = 1'b0;
    tick(2);

    // 4: request dropped in second strobe cycle still completes
    run_seq(0, 1, 2, "t4");
    tick(2);

    // 5: hard reset during third strobe cycle, re-arbitrate from ptr=0
    req[0] = 4'b0101;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      tick(1);
      if (rst_en[0] != 4'd0) seen = 1'b1;
    end
    check("t5_first_grant", 32'(rst_en[0]), 32'b0100);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("t5_strobe_drop", 32'(rst_en[0]), 32'd0);
    check("t5_busy_drop", 32'(busy[0]), 32'd0);
    check("t5_no_ack", 32'(ack[0]), 32'd0);
    tick(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      tick(1);
      if (rst_en[0] != 4'd0) seen = 1'b1;
    end
    check("t5_restart_ch", 32'(cur[0]), 32'd0);
    check("t5_restart_en", 32'(rst_en[0]), 32'b0001);
    for (int w = 0; w < 40 && req[0] != 4'd0; w++) begin
      tick(1);
      req[0] = req[0] & ~ack[0];
    end
    check("t5_drained", 32'(req[0]), 32'd0);

    // 6: minimal timing instance
    run_seq(1, 3, 0, "t6");
    run_seq(1, 0, 1, "t6b");

    // random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      tick(1);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = 4'($urandom);
        lock[i] = ($urandom_range(0, 4) == 0);
      end
    end
    req = '0; lock = '0;
    tick(15);
    check("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
